// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM timer.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_deadtime_insert.sv
// Dead-time stage for one channel: each gate rises only after raw has been stable at its level
// for DEAD_CYCLES prior cycles, so the complementary pair is never high together.
module pwm_deadtime_insert #(
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic pwm,
  output logic pwm_n
);

  localparam int unsigned CW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] Dead = CW'(DEAD_CYCLES);

  logic [CW-1:0] run_q, run_d;
  logic          prev_q;
  logic          settled;
  logic          pwm_q, pwm_n_q;

  // run_q counts how many earlier cycles raw already held its current level (saturating).
  always_comb begin
    settled = (raw == prev_q) && (run_q >= Dead);
    if (raw != prev_q) begin
      run_d = CW'(1);
    end else if (run_q < Dead) begin
      run_d = run_q + CW'(1);
    end else begin
      run_d = run_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q   <= '0;
      prev_q  <= 1'b0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      prev_q  <= raw;
      pwm_q   <= raw & settled;
      pwm_n_q <= ~raw & settled;
    end
  end

  assign pwm   = pwm_q;
  assign pwm_n = pwm_n_q;

endmodule

// File: rtl/multi_pwm_generator.sv
// Multi-channel PWM timer: shared edge/center counter, shadowed config applied at period boundary.
// Define PWM_DEADTIME_EN to insert dead time between the complementary gate outputs.
module multi_pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned DEFAULT_PERIOD = 1000,
  parameter int unsigned DEAD_CYCLES    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CNT_WIDTH-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_duty,
  input  pwm_mode_t                   cfg_mode,
  output logic [NUM_CH-1:0]           pwm,
  output logic [NUM_CH-1:0]           pwm_n,
  output logic                        period_end
);

  typedef logic [NUM_CH-1:0][CNT_WIDTH-1:0] duty_vec_t;

  localparam logic [CNT_WIDTH-1:0] MinP = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] DefP = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] One  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cnt_up_q, cnt_up_d;
  logic [CNT_WIDTH-1:0] period_q, period_d, sh_period_q, sh_period_d;
  duty_vec_t            duty_q, duty_d, sh_duty_q, sh_duty_d;
  pwm_mode_t            mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic                 pending_q, pending_d;
  logic                 period_end_q;
  logic [CNT_WIDTH-1:0] cfg_period_clamped;
  logic                 boundary, accept;
  logic [NUM_CH-1:0]    raw;

  assign cfg_ready          = rstn & ~pending_q;
  assign accept             = cfg_valid & cfg_ready;
  assign cfg_period_clamped = (cfg_period < MinP) ? MinP : cfg_period;
  assign boundary           = (mode_q == PWM_EDGE) ? (cnt_q == period_q - One)
                                                   : (!cnt_up_q && (cnt_q == '0));

  always_comb begin
    cnt_d       = cnt_q;
    cnt_up_d    = cnt_up_q;
    period_d    = period_q;
    duty_d      = duty_q;
    mode_d      = mode_q;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    sh_mode_d   = sh_mode_q;
    pending_d   = pending_q;

    if (boundary) begin
      cnt_d    = '0;
      cnt_up_d = 1'b1;
      // A word accepted in the boundary cycle bypasses the shadow set entirely.
      if (accept) begin
        period_d = cfg_period_clamped;
        duty_d   = cfg_duty;
        mode_d   = cfg_mode;
      end else if (pending_q) begin
        period_d = sh_period_q;
        duty_d   = sh_duty_q;
        mode_d   = sh_mode_q;
      end
      pending_d = 1'b0;
    end else begin
      if (mode_q == PWM_EDGE) begin
        cnt_d = cnt_q + One;
      end else if (!cnt_up_q) begin
        cnt_d = cnt_q - One;
      end else if (cnt_q == period_q - One) begin
        cnt_up_d = 1'b0;  // peak value is held for a second cycle while turning around
      end else begin
        cnt_d = cnt_q + One;
      end
      if (accept) begin
        sh_period_d = cfg_period_clamped;
        sh_duty_d   = cfg_duty;
        sh_mode_d   = cfg_mode;
        pending_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q        <= '0;
      cnt_up_q     <= 1'b1;
      period_q     <= DefP;
      duty_q       <= '0;
      mode_q       <= PWM_EDGE;
      sh_period_q  <= DefP;
      sh_duty_q    <= '0;
      sh_mode_q    <= PWM_EDGE;
      pending_q    <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cnt_up_q     <= cnt_up_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      mode_q       <= mode_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_mode_q    <= sh_mode_d;
      pending_q    <= pending_d;
      period_end_q <= boundary;
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = (cnt_q < duty_q[i]);
    end
  end

  assign period_end = period_end_q;

`ifdef PWM_DEADTIME_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_dt
    pwm_deadtime_insert #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_dt (
      .clk  (clk),
      .rstn (rstn),
      .raw  (raw[i]),
      .pwm  (pwm[i]),
      .pwm_n(pwm_n[i])
    );
  end
`else
  logic [NUM_CH-1:0] pwm_q, pwm_n_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pwm_q   <= '0;
      pwm_n_q <= '0;
    end else begin
      pwm_q   <= raw;
      pwm_n_q <= ~raw;
    end
  end

  assign pwm   = pwm_q;
  assign pwm_n = pwm_n_q;
`endif

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Randomized scoreboard bench for multi_pwm_generator against a period-level reference model.
module tb_multi_pwm_generator;
  import pwm_pkg::*;

  localparam int NUM_CH    = 2;
  localparam int CNT_WIDTH = 16;
  localparam int DEF_P     = 1000;
  localparam int DEAD      = 8;

  logic                        clk;
  logic                        rstn;
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [CNT_WIDTH-1:0]        cfg_period;
  logic [NUM_CH*CNT_WIDTH-1:0] cfg_duty;
  pwm_mode_t                   cfg_mode;
  logic [NUM_CH-1:0]           pwm;
  logic [NUM_CH-1:0]           pwm_n;
  logic                        period_end;

  multi_pwm_generator #(
    .NUM_CH        (NUM_CH),
    .CNT_WIDTH     (CNT_WIDTH),
    .DEFAULT_PERIOD(DEF_P),
    .DEAD_CYCLES   (DEAD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .cfg_mode  (cfg_mode),
    .pwm       (pwm),
    .pwm_n     (pwm_n),
    .period_end(period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] pwm_n;
    logic              pe;
    bit                pend;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: waveform position k within the current period; one record per clock edge.
  int   m_p, m_mode, m_k, m_len, m_v;
  int   m_duty[NUM_CH];
  int   s_p, s_mode;
  int   s_duty[NUM_CH];
  int   c_p, c_mode;
  int   c_duty[NUM_CH];
  bit   m_pend, m_bnd, m_acc;
  bit   m_raw[NUM_CH];
  int   run[NUM_CH];
  bit   last[NUM_CH];
  exp_t me;

  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_p = DEF_P; m_mode = 0; m_k = 0; m_pend = 0;
        for (int i = 0; i < NUM_CH; i++) begin
          m_duty[i] = 0; run[i] = 0; last[i] = 0;
        end
        me.pwm = '0; me.pwm_n = '0; me.pe = 1'b0; me.pend = 1'b0;
      end else begin
        c_p    = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
        c_mode = (cfg_mode == PWM_CENTER) ? 1 : 0;
        for (int i = 0; i < NUM_CH; i++) c_duty[i] = int'(cfg_duty[i*CNT_WIDTH +: CNT_WIDTH]);
        m_len = (m_mode != 0) ? 2 * m_p : m_p;
        m_v   = (m_k < m_p) ? m_k : 2 * m_p - 1 - m_k;
        for (int i = 0; i < NUM_CH; i++) begin
          m_raw[i] = (m_v < m_duty[i]);
`ifdef PWM_DEADTIME_EN
          run[i]  = (m_raw[i] == last[i]) ? run[i] + 1 : 1;
          last[i] = m_raw[i];
          me.pwm[i]   = m_raw[i] && (run[i] >= DEAD + 1);
          me.pwm_n[i] = !m_raw[i] && (run[i] >= DEAD + 1);
`else
          me.pwm[i]   = m_raw[i];
          me.pwm_n[i] = !m_raw[i];
`endif
        end
        m_bnd = (m_k == m_len - 1);
        m_acc = cfg_valid && !m_pend;
        me.pe = m_bnd;
        if (m_bnd) begin
          if (m_acc) begin
            m_p = c_p; m_mode = c_mode;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = c_duty[i];
          end else if (m_pend) begin
            m_p = s_p; m_mode = s_mode;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = s_duty[i];
          end
          m_pend = 0;
          m_k    = 0;
        end else begin
          m_k++;
          if (m_acc) begin
            s_p = c_p; s_mode = c_mode;
            for (int i = 0; i < NUM_CH; i++) s_duty[i] = c_duty[i];
            m_pend = 1;
          end
        end
        me.pend = m_pend;
      end
      sb.push_back(me);
    end
  end

  // Monitor: compares every registered output against the model once per cycle.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("pwm", 32'(pwm), 32'(mon_e.pwm));
        check("pwm_n", 32'(pwm_n), 32'(mon_e.pwm_n));
        check("period_end", 32'(period_end), 32'(mon_e.pe));
        check("cfg_ready", 32'(cfg_ready), 32'(rstn & ~mon_e.pend));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int p, input int d0, input int d1, input int mode);
    bit done;
    done       = 0;
    cfg_valid  = 1'b1;
    cfg_period = p[CNT_WIDTH-1:0];
    cfg_duty   = {d1[CNT_WIDTH-1:0], d0[CNT_WIDTH-1:0]};
    cfg_mode   = (mode != 0) ? PWM_CENTER : PWM_EDGE;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) done = 1;
      @(posedge clk);
      #2;
    end
    cfg_valid = 1'b0;
    check("cfg_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_pe();
    bit seen;
    seen = 0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      if (period_end === 1'b1) seen = 1;
    end
    check("period_end_seen", 32'(seen), 32'd1);
  endtask

  int rp, rd0, rd1, rm;

  initial begin
    rstn = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0; cfg_mode = PWM_EDGE;
    tick(4);
    rstn = 1'b1;
    tick(2100);
    send(10, 3, 10, 0);
    tick(45);
    send(8, 2, 5, 1);
    tick(60);
    send(6, 2, 6, 0);
    wait_pe();
    // Offer P=5 exactly in the boundary cycle of the first 6-cycle period.
    repeat (5) @(posedge clk);
    #2;
    send(5, 1, 4, 0);
    tick(20);
    send(6, 1, 4, 0);
    send(7, 3, 7, 1);
    tick(50);
    for (int n = 0; n < 16; n++) begin
      rp  = int'($urandom_range(0, 14));
      rd0 = int'($urandom_range(0, 16));
      rd1 = (n % 4 == 0) ? 0 : int'($urandom_range(0, 16));
      rm  = int'($urandom_range(0, 1));
      send(rp, rd0, rd1, rm);
      tick(int'($urandom_range(0, 40)));
      if (n == 8) begin
        send(9, 4, 2, 1);
        tick(3);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(10);
      end
    end
    tick(80);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
